reorder_buffer: RTL

- Circular reorder buffer (ROB) for the Tomasulo core; the ROB index is the tag carried by reservation-station entries and CDB broadcasts.
- Upstream: the decoder allocates one entry per dispatched instruction and receives its tag.
- Downstream: captures results from the CDB (ALU/CMP/LSU stations), commits in order to the register file, and raises a pipeline flush at commit of a mispredicted branch.
- Also serves dispatch-time operand lookup, so a station entry can be loaded with operands already marked valid.

---
 rtl/reorder_buffer_pkg.sv | 36 +++
 rtl/reorder_buffer_operand_lookup.sv | 36 +++
 rtl/reorder_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: entry and CDB lane layouts,
// the NORMAL/FLUSH state encoding and the wrap-bit pointer increment.
package reorder_buffer_pkg;

    localparam int RO_BUFFER_ENTRIES = 8;
    localparam int NUM_CDB_ENTRIES   = 4;
    localparam int TAG_W             = $clog2(RO_BUFFER_ENTRIES);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        mispredict;
        logic [31:0] target;
    } rob_entry_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } rob_state_e;

    // Pointers carry one extra wrap bit, so they count modulo twice the depth.
    function automatic logic [TAG_W:0] ptr_inc(input logic [TAG_W:0] ptr);
        return ptr + {{TAG_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/reorder_buffer_operand_lookup.sv
// Dispatch-time operand read: ROB entry lookup with same-cycle CDB bypass,
// so a freshly broadcast result is visible before it lands in the array.
module rob_operand_lookup
    import reorder_buffer_pkg::*;
(
    input  logic [RO_BUFFER_ENTRIES-1:0]       busy_vec,
    input  logic [RO_BUFFER_ENTRIES-1:0]       ready_vec,
    input  logic [RO_BUFFER_ENTRIES-1:0][31:0] value_vec,
    input  cdb_t                               cdb,
    input  logic [TAG_W-1:0]                   tag,
    output logic                               ready,
    output logic [31:0]                        value
);

    logic [NUM_CDB_ENTRIES-1:0] lane_hit_s;
    logic                       hit_s;
    logic [31:0]                lane_value_s;

    for (genvar l = 0; l < NUM_CDB_ENTRIES; l++) begin : g_lane
        assign lane_hit_s[l] = cdb[l].valid && (cdb[l].tag == tag);
    end

    assign hit_s = |lane_hit_s;

    // Later lanes override earlier ones, so the highest matching lane wins.
    always_comb begin
        lane_value_s = 32'd0;
        for (int l = 0; l < NUM_CDB_ENTRIES; l++) begin
            lane_value_s = lane_hit_s[l] ? cdb[l].value : lane_value_s;
        end
    end

    assign ready = busy_vec[tag] && (ready_vec[tag] || hit_s);
    assign value = !busy_vec[tag] ? 32'd0 : (hit_s ? lane_value_s : value_vec[tag]);

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/commit, CDB result capture,
// branch-resolve bookkeeping and a one-cycle flush on mispredict commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             rob_full,
    output logic             rob_empty,
    input  cdb_t             cdb_vals_i,
    input  logic             br_resolve_valid,
    input  logic [TAG_W-1:0] br_resolve_tag,
    input  logic             br_mispredict,
    input  logic [31:0]      br_target,
    input  logic [TAG_W-1:0] rs1_tag_i,
    input  logic [TAG_W-1:0] rs2_tag_i,
    output logic             rs1_ready_o,
    output logic             rs2_ready_o,
    output logic [31:0]      rs1_value_o,
    output logic [31:0]      rs2_value_o,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] commit_tag,
    output logic             flush_o,
    output logic [31:0]      flush_pc
);

    localparam int N = RO_BUFFER_ENTRIES;

    rob_entry_t             entries_r [N];
    rob_entry_t             entries_n [N];
    logic [TAG_W:0]         head_r, head_n;
    logic [TAG_W:0]         tail_r, tail_n;
    logic [TAG_W:0]         count_r, count_n;
    rob_state_e             state_r, state_n;
    logic [31:0]            flush_pc_r, flush_pc_n;

    logic [TAG_W-1:0]       head_idx_s, tail_idx_s;
    rob_entry_t             head_entry_s;
    logic                   full_s, empty_s;
    logic                   alloc_fire_s, commit_fire_s, flush_take_s, resolve_s;
    logic [NUM_CDB_ENTRIES-1:0] cdb_cap_s;
    logic [N-1:0]           busy_vec_s, ready_vec_s;
    logic [N-1:0][31:0]     value_vec_s;

    assign head_idx_s   = head_r[TAG_W-1:0];
    assign tail_idx_s   = tail_r[TAG_W-1:0];
    assign head_entry_s = entries_r[head_idx_s];

    assign full_s  = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
    assign empty_s = (head_r == tail_r);

    assign rob_full  = full_s || (state_r == ST_FLUSH);
    assign rob_empty = empty_s;
    assign alloc_tag = tail_idx_s;
    assign flush_o   = (state_r == ST_FLUSH);
    assign flush_pc  = flush_pc_r;

    assign alloc_fire_s  = alloc_valid && !rob_full;
    assign commit_fire_s = head_entry_s.busy && head_entry_s.ready && (state_r == ST_NORMAL);
    assign flush_take_s  = commit_fire_s && head_entry_s.mispredict;
    assign resolve_s     = br_resolve_valid && entries_r[br_resolve_tag].busy;

    assign commit_valid = commit_fire_s;
    assign commit_rd    = commit_fire_s ? head_entry_s.rd : 5'd0;
    assign commit_value = commit_fire_s ? head_entry_s.value : 32'd0;
    assign commit_tag   = head_idx_s;

    for (genvar l = 0; l < NUM_CDB_ENTRIES; l++) begin : g_cap
        assign cdb_cap_s[l] = cdb_vals_i[l].valid && entries_r[cdb_vals_i[l].tag].busy;
    end

    for (genvar i = 0; i < N; i++) begin : g_vec
        assign busy_vec_s[i]  = entries_r[i].busy;
        assign ready_vec_s[i] = entries_r[i].ready;
        assign value_vec_s[i] = entries_r[i].value;
    end

    rob_operand_lookup u_rs1_lookup (
        .busy_vec  (busy_vec_s),
        .ready_vec (ready_vec_s),
        .value_vec (value_vec_s),
        .cdb       (cdb_vals_i),
        .tag       (rs1_tag_i),
        .ready     (rs1_ready_o),
        .value     (rs1_value_o)
    );

    rob_operand_lookup u_rs2_lookup (
        .busy_vec  (busy_vec_s),
        .ready_vec (ready_vec_s),
        .value_vec (value_vec_s),
        .cdb       (cdb_vals_i),
        .tag       (rs2_tag_i),
        .ready     (rs2_ready_o),
        .value     (rs2_value_o)
    );

    // Next-state: capture, resolve, allocate and commit; a mispredict commit wipes everything.
    always_comb begin
        entries_n  = entries_r;
        head_n     = head_r;
        tail_n     = tail_r;
        count_n    = count_r;
        state_n    = ST_NORMAL;
        flush_pc_n = flush_pc_r;
        case (state_r)
            ST_NORMAL: begin
                for (int l = 0; l < NUM_CDB_ENTRIES; l++) begin
                    entries_n[cdb_vals_i[l].tag].ready = entries_n[cdb_vals_i[l].tag].ready | cdb_cap_s[l];
                    entries_n[cdb_vals_i[l].tag].value = cdb_cap_s[l] ? cdb_vals_i[l].value
                                                                      : entries_n[cdb_vals_i[l].tag].value;
                end
                entries_n[br_resolve_tag].mispredict = resolve_s ? br_mispredict
                                                                 : entries_n[br_resolve_tag].mispredict;
                entries_n[br_resolve_tag].target     = resolve_s ? br_target
                                                                 : entries_n[br_resolve_tag].target;
                if (alloc_fire_s) begin
                    entries_n[tail_idx_s] = '{busy: 1'b1, ready: 1'b0, rd: alloc_rd, value: 32'd0,
                                              mispredict: 1'b0, target: 32'd0};
                    tail_n = ptr_inc(tail_r);
                end else begin
                    tail_n = tail_r;
                end
                if (commit_fire_s) begin
                    entries_n[head_idx_s].busy = 1'b0;
                    head_n = ptr_inc(head_r);
                end else begin
                    head_n = head_r;
                end
                count_n = count_r + {{TAG_W{1'b0}}, alloc_fire_s} - {{TAG_W{1'b0}}, commit_fire_s};
                if (flush_take_s) begin
                    for (int i = 0; i < N; i++) begin
                        entries_n[i] = '0;
                    end
                    head_n     = '0;
                    tail_n     = '0;
                    count_n    = '0;
                    state_n    = ST_FLUSH;
                    flush_pc_n = head_entry_s.target;
                end else begin
                    state_n = ST_NORMAL;
                end
            end
            ST_FLUSH: begin
                state_n = ST_NORMAL;
            end
            default: begin
                state_n = ST_NORMAL;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                entries_r[i] <= '0;
            end
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            state_r    <= ST_NORMAL;
            flush_pc_r <= 32'd0;
        end else begin
            entries_r  <= entries_n;
            head_r     <= head_n;
            tail_r     <= tail_n;
            count_r    <= count_n;
            state_r    <= state_n;
            flush_pc_r <= flush_pc_n;
        end
    end

endmodule
